// File: rtl/instr_fetch_prefetcher.sv
// Sequential instruction prefetcher: issues word reads to the IRAM/boot-ROM wrapper,
// buffers returned words with their addresses, and streams them to the core.
//
// state | meaning
// IDLE  | fetching disabled; buffered words still drain to the core
// RUN   | issuing sequential reads whenever the buffer has room
module instr_fetch_prefetcher #(
  parameter int                    ADDR_WIDTH = 17,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 'h10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  inflight_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [31:0]           data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic                  pop, push, issue;
  logic [CW:0]           fill;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^branch_addr_i[1:0];

  assign instr_valid_o = (count_q != '0);
  assign pop  = instr_valid_o & instr_ready_i;
  assign push = inflight_q & ~branch_i;
  // Occupancy the buffer will see once the outstanding read lands, net of this cycle's pop.
  assign fill = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (!branch_i) begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_d = RUN;
        RUN:     if (!fetch_en_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    issue = (state_q == RUN) && fetch_en_i && !branch_i && (fill < DEPTH_W);
  end

  assign mem_en_o    = issue;
  assign mem_addr_o  = fetch_addr_q;
  assign mem_we_o    = 1'b0;
  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q    <= BOOT_ADDR;
      inflight_addr_q <= '0;
      inflight_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else if (branch_i) begin
      // Redirect wins over everything: the in-flight response and any pop are dropped.
      fetch_addr_q <= {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fetch_addr_q    <= fetch_addr_q + ADDR_WIDTH'(4);
        inflight_addr_q <= fetch_addr_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata_i;
      addr_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

  assign instr_rdata_o = instr_valid_o ? data_q[rd_ptr_q] : '0;
  assign instr_addr_o  = instr_valid_o ? addr_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
`endif

endmodule
